coef_updater: RTL

- Consumer of the per-sample error stream produced by the error calculator in the linear-regression datapath.
- Accepts N (error, x) pairs per epoch and accumulates sum(e) and sum(e*x).
- At epoch end, applies one gradient-descent step to b0/b1 with a shift-based learning rate and saturation, then pulses done.
- Sits between the error calculator (upstream) and the top-level controller that sequences epochs.

---
 rtl/lr_pkg.sv | 20 ++
 rtl/coef_updater_if.sv | 13 +
 rtl/sat_add.sv | 23 ++
 rtl/coef_updater.sv | 108 ++++++++++
 4 files changed

// File: rtl/lr_pkg.sv
// rtl/lr_pkg.sv - shared constants, state encoding and saturation bounds for the coefficient updater
package lr_pkg;

    localparam int W            = 20;
    localparam int FRAC         = 10;
    localparam int ACC_W        = 32;
    localparam int N_DEF        = 150;
    localparam int LR_SHIFT_DEF = 6;

    localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/coef_updater_if.sv
// rtl/coef_updater_if.sv - per-sample error stream between the error calculator and the updater
interface coef_updater_if;

    logic                          e_valid;
    logic signed [lr_pkg::W-1:0]   e_in;
    logic signed [lr_pkg::W-1:0]   x_in;
    logic                          e_ready;
    logic [7:0]                    idx;

    modport master (output e_valid, output e_in, output x_in, input e_ready, input idx);
    modport slave  (input e_valid, input e_in, input x_in, output e_ready, output idx);

endinterface

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed ACC_W+1 bit add of a coefficient and a step, clamped to W bits
module sat_add
    import lr_pkg::*;
(
    input  logic signed [W-1:0]     a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [W-1:0]     y
);

    logic signed [ACC_W:0] sum;

    assign sum = (ACC_W+1)'(a) + (ACC_W+1)'(b);

    always_comb begin
        y = sum[W-1:0];
        if (sum > (ACC_W+1)'(W_MAX)) begin
            y = W_MAX;
        end else if (sum < (ACC_W+1)'(W_MIN)) begin
            y = W_MIN;
        end
    end

endmodule

// File: rtl/coef_updater.sv
// rtl/coef_updater.sv - accumulates sum(e) and sum(e*x) over an epoch, then takes one gradient step on b0/b1
module coef_updater
    import lr_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int LR_SHIFT = LR_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic signed [W-1:0] b0_init,
    input  logic signed [W-1:0] b1_init,
    input  logic                start,
    coef_updater_if.slave       smp,
    output logic signed [W-1:0] b0,
    output logic signed [W-1:0] b1,
    output logic                busy,
    output logic                done
);

    state_t                  state;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc_e;
    logic signed [ACC_W-1:0] acc_ex;
    logic [7:0]              idx;
    logic                    xfer;
    logic                    last;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] term_ex;
    logic signed [ACC_W-1:0] step_e;
    logic signed [ACC_W-1:0] step_ex;
    logic signed [W-1:0]     b0_upd;
    logic signed [W-1:0]     b1_upd;

    assign xfer    = (state == ACCUM) && smp.e_valid;
    assign last    = (idx == 8'(N - 1));
    assign prod    = smp.e_in * smp.x_in;
    // Full-width product is rescaled first, then sign-extended or truncated to the accumulator.
    assign term_ex = ACC_W'(prod >>> FRAC);
    assign step_e  = acc_e >>> LR_SHIFT;
    assign step_ex = acc_ex >>> LR_SHIFT;
    assign smp.idx = idx;

    sat_add u_sat_b0 (.a(b0), .b(step_e),  .y(b0_upd));
    sat_add u_sat_b1 (.a(b1), .b(step_ex), .y(b1_upd));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (xfer && last) state_nxt = UPDATE;
            UPDATE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        smp.e_ready = (state == ACCUM);
        busy        = (state != IDLE);
        done        = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            b0     <= '0;
            b1     <= '0;
            acc_e  <= '0;
            acc_ex <= '0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        b0 <= b0_init;
                        b1 <= b1_init;
                    end
                    if (start) begin
                        acc_e  <= '0;
                        acc_ex <= '0;
                        idx    <= '0;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_e  <= acc_e + ACC_W'(smp.e_in);
                        acc_ex <= acc_ex + term_ex;
                        idx    <= last ? 8'd0 : idx + 8'd1;
                    end
                end
                UPDATE: begin
                    b0 <= b0_upd;
                    b1 <= b1_upd;
                end
                default: ;
            endcase
        end
    end

endmodule
